// File: rtl/a51_keystream_ctrl.sv
// A5/1 control and keystream stage: key load, majority-clocked warm-up,
// keystream byte packing and valid/ready hand-off to the pixel XOR stage.
module a51_keystream_ctrl #(
  parameter int WARMUP    = 100,
  parameter int NUM_BYTES = 1024,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       x_out,
  input  logic       y_out,
  input  logic       z_out,
  input  logic       x_maj,
  input  logic       y_maj,
  input  logic       z_maj,
  output logic       load,
  output logic       x_trig,
  output logic       y_trig,
  output logic       z_trig,
  output logic [7:0] ks_byte,
  output logic       ks_valid,
  input  logic       ks_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_GEN,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] NB_LAST   = CNT_W'(NUM_BYTES - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] warm_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [2:0]       bit_cnt;
  logic [6:0]       sr;
  logic             maj;
  logic             k;

  assign maj = (x_maj & y_maj) | (x_maj & z_maj) | (y_maj & z_maj);
  assign k   = x_out ^ y_out ^ z_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    x_trig   = 1'b0;
    y_trig   = 1'b0;
    z_trig   = 1'b0;
    ks_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        load = 1'b1;
        if (WARMUP == 0) state_nx = S_GEN;
        else             state_nx = S_WARM;
      end
      S_WARM: begin
        x_trig = (x_maj == maj);
        y_trig = (y_maj == maj);
        z_trig = (z_maj == maj);
        if (warm_cnt == WARM_LAST) state_nx = S_GEN;
      end
      S_GEN: begin
        x_trig = (x_maj == maj);
        y_trig = (y_maj == maj);
        z_trig = (z_maj == maj);
        if (bit_cnt == 3'd7) state_nx = S_HOLD;
      end
      S_HOLD: begin
        ks_valid = 1'b1;
        if (ks_ready) begin
          if (byte_cnt == NB_LAST) state_nx = S_DONE;
          else                     state_nx = S_GEN;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // k is taken before the shift the same-cycle triggers cause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      ks_byte  <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          warm_cnt <= '0;
          byte_cnt <= '0;
          bit_cnt  <= '0;
        end
        S_WARM: warm_cnt <= warm_cnt + CNT_W'(1);
        S_GEN: begin
          sr      <= {sr[5:0], k};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) ks_byte <= {sr, k};
        end
        S_HOLD: begin
          if (ks_ready) byte_cnt <= byte_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_a51_keystream_ctrl.sv
// Bench for a51_keystream_ctrl: directed pin-level cases plus randomized
// keys against a software A5/1 keystream model.
module tb_a51_keystream_ctrl;

  localparam int WARM = 4;
  localparam int NB   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       x_out, y_out, z_out;
  logic       x_maj, y_maj, z_maj;
  logic       load;
  logic       x_trig, y_trig, z_trig;
  logic [7:0] ks_byte;
  logic       ks_valid;
  logic       ks_ready;
  logic       busy;
  logic       done;

  a51_keystream_ctrl #(
    .WARMUP(WARM),
    .NUM_BYTES(NB),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .x_out(x_out),
    .y_out(y_out),
    .z_out(z_out),
    .x_maj(x_maj),
    .y_maj(y_maj),
    .z_maj(z_maj),
    .load(load),
    .x_trig(x_trig),
    .y_trig(y_trig),
    .z_trig(z_trig),
    .ks_byte(ks_byte),
    .ks_valid(ks_valid),
    .ks_ready(ks_ready),
    .busy(busy),
    .done(done)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // manual pin drive or three LFSR register models
  logic        man;
  logic        m_xo, m_yo, m_zo, m_xm, m_ym, m_zm;
  logic [63:0] key;
  logic [18:0] rx;
  logic [21:0] ry;
  logic [22:0] rz;

  assign x_out = man ? m_xo : rx[18];
  assign y_out = man ? m_yo : ry[21];
  assign z_out = man ? m_zo : rz[22];
  assign x_maj = man ? m_xm : rx[8];
  assign y_maj = man ? m_ym : ry[10];
  assign z_maj = man ? m_zm : rz[10];

  always @(posedge clk) begin
    if (load) begin
      rx <= key[18:0];
      ry <= key[40:19];
      rz <= key[63:41];
    end else begin
      if (x_trig) rx <= {rx[17:0], rx[18] ^ rx[17] ^ rx[16] ^ rx[13]};
      if (y_trig) ry <= {ry[20:0], ry[21] ^ ry[20]};
      if (z_trig) rz <= {rz[21:0], rz[22] ^ rz[21] ^ rz[20] ^ rz[7]};
    end
  end

  int hs_cnt;
  int load_cnt;
  int excl_err;

  always @(posedge clk) begin
    if (ks_valid && ks_ready) hs_cnt++;
    if (load) load_cnt++;
    if (load && (x_trig || y_trig || z_trig)) excl_err++;
  end

  wire [14:0] outs = {load, x_trig, y_trig, z_trig,
                      ks_valid, busy, done, ks_byte};

  logic [7:0] exp_q[$];

  // software A5/1: clock by majority, emit XOR of MSBs before each step
  task automatic ref_fill(input logic [63:0] kk);
    logic [18:0] x;
    logic [21:0] y;
    logic [22:0] z;
    logic [7:0]  b;
    logic        kb;
    logic        m;
    x = kk[18:0];
    y = kk[40:19];
    z = kk[63:41];
    b = 8'h00;
    exp_q.delete();
    for (int i = 0; i < WARM + 8 * NB; i++) begin
      kb = x[18] ^ y[21] ^ z[22];
      m  = (int'(x[8]) + int'(y[10]) + int'(z[10])) >= 2;
      if (i >= WARM) begin
        b = {b[6:0], kb};
        if ((i - WARM) % 8 == 7) exp_q.push_back(b);
      end
      if (x[8] == m) x = {x[17:0], x[18] ^ x[17] ^ x[16] ^ x[13]};
      if (y[10] == m) y = {y[20:0], y[21] ^ y[20]};
      if (z[10] == m) z = {z[21:0], z[22] ^ z[21] ^ z[20] ^ z[7]};
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!ks_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_to"}, 32'(ks_valid), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         idx;
    logic       m;
    logic [2:0] c;
    logic [2:0] et;
    logic [7:0] saved;
    logic       seen_done;

    rst = 1'b1; start = 1'b0; ks_ready = 1'b0;
    man = 1'b1; key = '0;
    m_xo = 1'b0; m_yo = 1'b0; m_zo = 1'b0;
    m_xm = 1'b0; m_ym = 1'b0; m_zm = 1'b0;
    hs_cnt = 0; load_cnt = 0; excl_err = 0;
    repeat (2) @(negedge clk);
    check("rst_outs", 32'(outs), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // directed run: constant x_out=1, majority probes, backpressure
    m_xo = 1'b1;
    ks_ready = 1'b1;
    pulse_start();
    check("load_on", 32'({load, busy}), 32'b11);
    @(negedge clk);
    check("load_1cyc", 32'(load), 32'd0);
    for (int i = 0; i < 8; i++) begin
      c = 3'(i);
      m_xm = c[2]; m_ym = c[1]; m_zm = c[0];
      #1;
      m  = (int'(c[2]) + int'(c[1]) + int'(c[0])) >= 2;
      et = {c[2] == m, c[1] == m, c[0] == m};
      check("maj", 32'({x_trig, y_trig, z_trig}), 32'(et));
    end
    m_xm = 1'b0; m_ym = 1'b0; m_zm = 1'b0;
    n = 1;
    while (!ks_valid && n < 200) begin
      @(negedge clk);
      n++;
      start = (n == 2);
    end
    start = 1'b0;
    check("latency", 32'(n), 32'(WARM + 9));
    check("byte_ff", 32'(ks_byte), 32'hff);
    m_xo = 1'b0;
    @(negedge clk);
    ks_ready = 1'b0;
    wait_valid("b2");
    check("byte_00", 32'(ks_byte), 32'h00);
    saved = ks_byte;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold",
            32'({ks_valid, x_trig, y_trig, z_trig, ks_byte}),
            32'({1'b1, 3'b000, saved}));
    end
    ks_ready = 1'b1;
    @(negedge clk);
    check("gen_next", 32'({ks_valid, x_trig, y_trig, z_trig}), 32'b0111);
    for (int i = 0; i < 8; i++) begin
      m_xo = (i % 2 == 0);
      @(negedge clk);
    end
    check("byte_aa", 32'({ks_valid, ks_byte}), 32'h1aa);
    @(negedge clk);
    check("done_on", 32'({done, busy, ks_valid}), 32'b110);
    @(negedge clk);
    check("done_off", 32'({done, busy}), 32'b00);
    check("hs_cnt", 32'(hs_cnt), 32'(NB));
    check("load_cnt", 32'(load_cnt), 32'd1);

    // reset in the middle of GEN
    man = 1'b0;
    key = {$urandom, $urandom};
    pulse_start();
    repeat (7) @(negedge clk);
    #3 rst = 1'b1;
    #1 check("rst_mid", 32'(outs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_idle", 32'(busy), 32'd0);

    // random keys, random backpressure, software reference
    for (int r = 0; r < 3; r++) begin
      key = {$urandom, $urandom};
      ref_fill(key);
      hs_cnt = 0;
      idx = 0;
      seen_done = 1'b0;
      pulse_start();
      n = 0;
      while (!seen_done && n < 600) begin
        ks_ready = 1'($urandom % 2);
        if (ks_valid && ks_ready && idx < exp_q.size()) begin
          check($sformatf("gold%0d_%0d", r, idx), 32'(ks_byte),
                32'(exp_q[idx]));
          idx++;
        end
        @(negedge clk);
        n++;
        if (done) seen_done = 1'b1;
      end
      check("gold_done", 32'(seen_done), 32'd1);
      check("gold_n", 32'(idx), 32'(NB));
      check("gold_hs", 32'(hs_cnt), 32'(NB));
    end
    check("excl", 32'(excl_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
